// File: rtl/pc_seq_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_seq_if                                                    |
// | Description : Request/status bundle between the control-unit FSM and the   |
// |               pc_seq program-counter sequencer.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Signals                                                                    |
// |   PCup, PCld, PCbr, PCcall, PCret : operation requests (control -> pc_seq) |
// |   LdAddr[AW], BrOff[OW], CallAddr : operands           (control -> pc_seq) |
// |   PC_out[AW]                      : registered program counter             |
// |   StkDepth, StkFull, StkEmpty     : return-stack occupancy                 |
// |   StkErr                          : sticky overflow/underflow flag         |
// |   Wrap                            : limit-wrap pulse (PC_LIMIT_EN only)    |
// | Modports                                                                   |
// |   master : control unit side                                               |
// |   slave  : pc_seq side                                                     |
// | Macro       : PC_LIMIT_EN adds the Wrap signal.                            |
// +----------------------------------------------------------------------------+
interface pc_seq_if #(
   parameter int AW    = 7,
   parameter int OW    = 4,
   parameter int DEPTH = 4
);
   localparam int c_DW = $clog2(DEPTH + 1);

   logic          PCup;
   logic          PCld;
   logic [AW-1:0] LdAddr;
   logic          PCbr;
   logic [OW-1:0] BrOff;
   logic          PCcall;
   logic [AW-1:0] CallAddr;
   logic          PCret;
   logic [AW-1:0] PC_out;
   logic [c_DW-1:0] StkDepth;
   logic          StkFull;
   logic          StkEmpty;
   logic          StkErr;
`ifdef PC_LIMIT_EN
   logic          Wrap;
`endif

   modport master (
      output PCup, PCld, LdAddr, PCbr, BrOff, PCcall, CallAddr, PCret,
      input  PC_out, StkDepth, StkFull, StkEmpty, StkErr
`ifdef PC_LIMIT_EN
      , input Wrap
`endif
   );

   modport slave (
      input  PCup, PCld, LdAddr, PCbr, BrOff, PCcall, CallAddr, PCret,
      output PC_out, StkDepth, StkFull, StkEmpty, StkErr
`ifdef PC_LIMIT_EN
      , output Wrap
`endif
   );
endinterface
`default_nettype wire

// File: rtl/pc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pc_seq                                                       |
// | Description : Parametrised program-counter sequencer: clear, increment,    |
// |               absolute load, signed relative branch and call/return with   |
// |               a DEPTH-entry return-address stack. One PC-changing          |
// |               operation per clock, fixed priority:                         |
// |               Clr > PCld > PCbr > PCret > PCcall > PCup > hold.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   Clk : clock, all state on posedge                                        |
// |   Clr : synchronous active-high clear (top priority)                       |
// |   bus : pc_seq_if.slave - requests, operands and registered status         |
// | Parameters                                                                 |
// |   AW (7) address width, OW (4) branch offset width (OW <= AW),             |
// |   DEPTH (4) stack entries, PC_LIMIT (2**AW, PC_LIMIT_EN only)              |
// | Macro       : PC_LIMIT_EN - any new PC >= PC_LIMIT becomes 0 and Wrap      |
// |               pulses for one cycle; pushed return addresses are limited    |
// |               the same way.                                                |
// +----------------------------------------------------------------------------+
module pc_seq #(
   parameter int AW    = 7,
   parameter int OW    = 4,
   parameter int DEPTH = 4
`ifdef PC_LIMIT_EN
   , parameter int PC_LIMIT = 2**AW
`endif
) (
   input  wire logic Clk,
   input  wire logic Clr,
   pc_seq_if.slave   bus
);
   localparam int c_DW = $clog2(DEPTH + 1);
   localparam int c_IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]   r_pc;
   logic [c_DW-1:0] r_depth;
   logic            r_err;
   logic [AW-1:0]   r_stack [DEPTH];

   logic [AW-1:0]   w_pc_nxt;
   logic [AW-1:0]   w_pc_raw;
   logic [c_DW-1:0] w_depth_nxt;
   logic            w_err_nxt;
   logic            w_push;
   logic            w_chg;
   logic            w_full;
   logic            w_empty;
   logic [AW-1:0]   w_ret_addr;
   logic [AW-1:0]   w_sext;
   logic [c_IW-1:0] w_push_idx;
   logic [c_IW-1:0] w_pop_idx;

   assign w_full     = (r_depth == c_DW'(DEPTH));
   assign w_empty    = (r_depth == '0);
   // Size cast of a signed operand sign-extends the offset to AW bits.
   assign w_sext     = AW'($signed(bus.BrOff));
   assign w_push_idx = c_IW'(r_depth);
   assign w_pop_idx  = c_IW'(r_depth - c_DW'(1));

`ifdef PC_LIMIT_EN
   logic r_wrap;
   logic w_wrap_nxt;
   logic [AW-1:0] w_inc;

   assign w_inc      = r_pc + AW'(1);
   assign w_ret_addr = (int'(w_inc) >= PC_LIMIT) ? '0 : w_inc;
`else
   assign w_ret_addr = r_pc + AW'(1);
`endif

   // Priority select; a blocked call/ret flags the error but leaves PC alone.
   always_comb begin
      w_pc_raw    = r_pc;
      w_depth_nxt = r_depth;
      w_err_nxt   = r_err;
      w_push      = 1'b0;
      w_chg       = 1'b0;
      if (bus.PCld) begin
         w_pc_raw = bus.LdAddr;
         w_chg    = 1'b1;
      end else if (bus.PCbr) begin
         w_pc_raw = r_pc + w_sext;
         w_chg    = 1'b1;
      end else if (bus.PCret) begin
         if (w_empty) begin
            w_err_nxt = 1'b1;
         end else begin
            w_pc_raw    = r_stack[w_pop_idx];
            w_depth_nxt = r_depth - c_DW'(1);
            w_chg       = 1'b1;
         end
      end else if (bus.PCcall) begin
         if (w_full) begin
            w_err_nxt = 1'b1;
         end else begin
            w_pc_raw    = bus.CallAddr;
            w_depth_nxt = r_depth + c_DW'(1);
            w_push      = 1'b1;
            w_chg       = 1'b1;
         end
      end else if (bus.PCup) begin
         w_pc_raw = r_pc + AW'(1);
         w_chg    = 1'b1;
      end
   end

`ifdef PC_LIMIT_EN
   // Only freshly computed values are limited; a held PC is already legal.
   always_comb begin
      w_pc_nxt   = w_pc_raw;
      w_wrap_nxt = 1'b0;
      if (w_chg && (int'(w_pc_raw) >= PC_LIMIT)) begin
         w_pc_nxt   = '0;
         w_wrap_nxt = 1'b1;
      end
   end
`else
   assign w_pc_nxt = w_pc_raw;
`endif

   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_pc    <= '0;
         r_depth <= '0;
         r_err   <= 1'b0;
      end else begin
         r_pc    <= w_pc_nxt;
         r_depth <= w_depth_nxt;
         r_err   <= w_err_nxt;
      end
   end

`ifdef PC_LIMIT_EN
   always_ff @(posedge Clk) begin
      if (Clr) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_wrap_nxt;
      end
   end
   assign bus.Wrap = r_wrap;
`endif

   // Stack storage is not reset; entries above StkDepth are don't-care.
   always_ff @(posedge Clk) begin
      if (!Clr && w_push) begin
         r_stack[w_push_idx] <= w_ret_addr;
      end
   end

   assign bus.PC_out   = r_pc;
   assign bus.StkDepth = r_depth;
   assign bus.StkFull  = w_full;
   assign bus.StkEmpty = w_empty;
   assign bus.StkErr   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_pc_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pc_seq                                                    |
// | Description : Directed vector bench for pc_seq (AW=7, OW=4, DEPTH=4;       |
// |               PC_LIMIT=100 when PC_LIMIT_EN is defined).                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pc_seq;
   localparam int c_AW    = 7;
   localparam int c_OW    = 4;
   localparam int c_DEPTH = 4;

   logic Clk = 1'b0;
   logic Clr;
   int   checks   = 0;
   int   failures = 0;

   always #5 Clk = ~Clk;

   pc_seq_if #(.AW(c_AW), .OW(c_OW), .DEPTH(c_DEPTH)) bus ();

   pc_seq #(
      .AW(c_AW), .OW(c_OW), .DEPTH(c_DEPTH)
`ifdef PC_LIMIT_EN
      , .PC_LIMIT(100)
`endif
   ) dut (
      .Clk(Clk),
      .Clr(Clr),
      .bus(bus)
   );

   typedef struct {
      bit       clr, up, ld, br, call, ret;
      bit [6:0] la, ca;
      bit [3:0] bo;
      int       pc, depth;
      bit       err, wrap;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit clr, input bit up, input bit ld, input bit [6:0] la,
                      input bit br, input bit [3:0] bo, input bit call, input bit [6:0] ca,
                      input bit ret, input int pc, input int depth, input bit err,
                      input bit wrap);
      vec_t v;
      v.clr = clr; v.up = up; v.ld = ld; v.la = la; v.br = br; v.bo = bo;
      v.call = call; v.ca = ca; v.ret = ret; v.pc = pc; v.depth = depth;
      v.err = err; v.wrap = wrap;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      Clr        = v.clr;
      bus.PCup   = v.up;
      bus.PCld   = v.ld;
      bus.LdAddr = v.la;
      bus.PCbr   = v.br;
      bus.BrOff  = v.bo;
      bus.PCcall = v.call;
      bus.CallAddr = v.ca;
      bus.PCret  = v.ret;
   endtask

   task automatic check_state(input string tag, input int pc, input int depth,
                              input bit err, input bit wrap);
      chk({tag, " PC_out"},   int'(bus.PC_out),   pc);
      chk({tag, " StkDepth"}, int'(bus.StkDepth), depth);
      chk({tag, " StkFull"},  int'(bus.StkFull),  (depth == c_DEPTH) ? 1 : 0);
      chk({tag, " StkEmpty"}, int'(bus.StkEmpty), (depth == 0) ? 1 : 0);
      chk({tag, " StkErr"},   int'(bus.StkErr),   int'(err));
`ifdef PC_LIMIT_EN
      chk({tag, " Wrap"},     int'(bus.Wrap),     int'(wrap));
`else
      if (wrap) chk({tag, " wrap-expect"}, 0, 1);
`endif
   endtask

   task automatic step(input vec_t v, input string tag);
      @(negedge Clk);
      drive(v);
      @(posedge Clk);
      #1;
      check_state(tag, v.pc, v.depth, v.err, v.wrap);
   endtask

   initial begin
      vec_t idle;
      idle = '{default: 0};
      drive(idle);
      Clr = 1'b1;

      //   clr up ld la   br bo    call ca  ret   pc  d  err w
      add(1, 1, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 0);
      add(1, 1, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 0);
      add(0, 1, 0, 0,   0, 4'h0, 0, 0,  0,    1,  0, 0, 0);
      add(0, 1, 0, 0,   0, 4'h0, 0, 0,  0,    2,  0, 0, 0);
      add(0, 1, 0, 0,   0, 4'h0, 0, 0,  0,    3,  0, 0, 0);
`ifndef PC_LIMIT_EN
      add(0, 0, 1, 127, 0, 4'h0, 0, 0,  0,  127,  0, 0, 0);
      add(0, 1, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 0);
      add(0, 0, 1, 2,   0, 4'h0, 0, 0,  0,    2,  0, 0, 0);
      add(0, 0, 0, 0,   1, 4'hC, 0, 0,  0,  126,  0, 0, 0);
      add(0, 0, 1, 127, 0, 4'h0, 0, 0,  0,  127,  0, 0, 0);
      add(0, 0, 0, 0,   1, 4'h1, 0, 0,  0,    0,  0, 0, 0);
`endif
      // branch and load priority
      add(0, 0, 1, 10,  0, 4'h0, 0, 0,  0,   10,  0, 0, 0);
      add(0, 0, 0, 0,   1, 4'hD, 0, 0,  0,    7,  0, 0, 0);
      add(0, 0, 0, 0,   1, 4'h7, 0, 0,  0,   14,  0, 0, 0);
`ifndef PC_LIMIT_EN
      add(0, 1, 1, 100, 1, 4'h3, 0, 0,  0,  100,  0, 0, 0);
`else
      add(0, 1, 1, 90,  1, 4'h3, 0, 0,  0,   90,  0, 0, 0);
`endif
      // nested call / return
      add(0, 0, 1, 5,   0, 4'h0, 0, 0,  0,    5,  0, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 40, 0,   40,  1, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 60, 0,   60,  2, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,   41,  1, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,    6,  0, 0, 0);
      // overflow, sticky error, clear
      add(1, 0, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 10, 0,   10,  1, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 20, 0,   20,  2, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 30, 0,   30,  3, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 50, 0,   50,  4, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 70, 0,   50,  4, 1, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,   31,  3, 1, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,   21,  2, 1, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,   11,  1, 1, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,    1,  0, 1, 0);
      add(1, 0, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 0);
      // underflow beats increment; clear beats call
      add(0, 1, 0, 0,   0, 4'h0, 0, 0,  1,    0,  0, 1, 0);
      add(1, 0, 0, 0,   0, 4'h0, 1, 40, 0,    0,  0, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,    0,  0, 1, 0);
      add(1, 0, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 0);
      // branch beats ret/call/up; ret beats call; zero offset holds
      add(0, 0, 0, 0,   0, 4'h0, 1, 20, 0,   20,  1, 0, 0);
      add(0, 1, 0, 0,   1, 4'h1, 1, 99, 1,   21,  1, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 99, 1,    1,  0, 0, 0);
      add(0, 0, 0, 0,   1, 4'h0, 0, 0,  0,    1,  0, 0, 0);
`ifdef PC_LIMIT_EN
      add(0, 0, 1, 99,  0, 4'h0, 0, 0,  0,   99,  0, 0, 0);
      add(0, 1, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 1);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  0,    0,  0, 0, 0);
      add(0, 0, 1, 120, 0, 4'h0, 0, 0,  0,    0,  0, 0, 1);
      add(0, 0, 1, 50,  0, 4'h0, 0, 0,  0,   50,  0, 0, 0);
      add(0, 0, 1, 99,  0, 4'h0, 0, 0,  0,   99,  0, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 1, 10, 0,   10,  1, 0, 0);
      add(0, 0, 0, 0,   0, 4'h0, 0, 0,  1,    0,  0, 0, 0);
`endif

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i], $sformatf("vec%0d", i));
      end

      // Sticky error survives idle cycles and other operations until Clr.
      begin
         vec_t v;
         v = '{default: 0};
         v.ld = 1; v.la = 7'd33; v.pc = 33;
         step(v, "seq ld33");
         v = '{default: 0};
         v.ret = 1; v.pc = 33; v.err = 1;
         step(v, "seq underflow");
         for (int k = 0; k < 4; k++) begin
            v = '{default: 0};
            v.pc = 33; v.err = 1;
            step(v, $sformatf("seq idle%0d", k));
         end
         v = '{default: 0};
         v.up = 1; v.pc = 34; v.err = 1;
         step(v, "seq up-after-err");
         v = '{default: 0};
         v.clr = 1; v.up = 1; v.pc = 0;
         step(v, "seq clr");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Parametrised successor to the 7-bit program counter; same clear/increment core, plus absolute load, signed relative branch, and a call/return address stack of configurable depth.
- Sits between the control-unit FSM and instruction memory; PC_out drives the instruction-ROM address directly.
- Exactly one PC-changing operation takes effect per clock, selected by fixed priority.

Parameters:
- AW, 7, PC/address width in bits.
- OW, 4, branch offset width in bits; offset is two's complement; OW <= AW.
- DEPTH, 4, return-address stack entries; DEPTH >= 1.
- PC_LIMIT, 2**AW, first illegal address; used only under PC_LIMIT_EN.

Ports:
- Clk  in  1  clock, all state updates on posedge.
- Clr  in  1  synchronous active-high reset/clear.
- PCup  in  1  increment PC by 1.
- PCld  in  1  load PC from LdAddr.
- LdAddr  in  AW  absolute load target.
- PCbr  in  1  relative branch.
- BrOff  in  OW  signed branch offset, relative to current PC_out.
- PCcall  in  1  call: push return address, jump to CallAddr.
- CallAddr  in  AW  call target.
- PCret  in  1  return: pop top of stack into PC.
- PC_out  out  AW  current program counter (registered).
- StkDepth  out  $clog2(DEPTH+1)  number of valid stack entries.
- StkFull  out  1  StkDepth == DEPTH (combinational from depth register).
- StkEmpty  out  1  StkDepth == 0 (combinational from depth register).
- StkErr  out  1  sticky error: overflow or underflow attempted.
- Wrap  out  1  one-cycle pulse on limit wrap; present only with PC_LIMIT_EN.

Behaviour:
- Single clock Clk; reset Clr is synchronous, active-high. It has top priority, overriding all other inputs in the same cycle.
- On Clr:
  - PC_out=0, StkDepth=0, StkErr=0, Wrap=0.
  - Stack RAM contents are not cleared; they are don't-care.
  - Clr mid-sequence discards any pending stack state.
- Priority (highest first): Clr > PCld > PCbr > PCret > PCcall > PCup > hold. Lower-priority requests asserted in the same cycle are ignored, with no side effects and no stack change.
- PCld: PC_out <= LdAddr.
- PCbr: PC_out <= PC_out + sign-extend(BrOff), modulo 2**AW.
  - BrOff = 0 holds PC.
  - Examples (AW=7): PC=2, BrOff=-4 gives 126; PC=127, BrOff=+1 gives 0.
- PCup: PC_out <= PC_out + 1, modulo 2**AW; 127 -> 0 for AW=7.
- PCcall, stack not full:
  - stack[StkDepth] <= PC_out + 1 (mod 2**AW).
  - StkDepth++.
  - PC_out <= CallAddr.
- PCcall, stack full:
  - No push, PC_out holds, StkErr <= 1.
- PCret, stack not empty:
  - PC_out <= stack[StkDepth-1].
  - StkDepth--.
- PCret, stack empty:
  - PC_out holds, StkErr <= 1.
- StkErr stays set until Clr; nothing else clears it.
- Latency:
  - All operations take effect on PC_out at the posedge where the request is sampled, so the new value is visible one cycle after request assertion.
  - StkDepth/StkFull/StkEmpty update on the same edge.
- No combinational path from any input to any output; outputs depend only on registers.
- Inputs are sampled only at posedge; the bench drives them on negedge.

Optional Feature:
- Macro: PC_LIMIT_EN.
- Defined:
  - Any computed next-PC (from increment, branch, load, call target or popped value) that is >= PC_LIMIT is replaced by 0.
  - Wrap pulses high for exactly the one cycle following that edge.
  - A pushed return address >= PC_LIMIT is pushed as 0.
- Undefined:
  - No Wrap port and no limit logic.
  - Arithmetic wraps naturally at 2**AW.

Test Plan:
- Clr=1 for 2 cycles with PCup=1 -> PC_out=0, StkDepth=0, StkEmpty=1, StkErr=0; release Clr with PCup=1 -> PC_out counts 1, 2, 3 on successive edges; from PC=127, one more PCup -> 0.
- PC=10; PCbr, BrOff=-3 -> 7; then PCbr, BrOff=+7 -> 14; then PCld, LdAddr=100 with PCup=1 and PCbr=1 asserted together -> 100 (load wins).
- PC=5; PCcall, CallAddr=40 -> PC=40, depth 1; PCcall, CallAddr=60 -> PC=60, depth 2; PCret -> 41; PCret -> 6, StkEmpty=1.
- DEPTH=4: 4 calls -> StkFull=1; 5th call -> PC unchanged, depth 4, StkErr=1; StkErr remains 1 after 4 returns; Clr -> StkErr=0.
- Empty stack; PCret with PCup=1 -> PC unchanged, StkErr=1 (ret wins over up); Clr asserted with PCcall -> PC=0, depth 0, nothing pushed.
- PC_LIMIT_EN with PC_LIMIT=100: PC=99, PCup -> PC=0 and Wrap=1 for one cycle; PCld LdAddr=120 -> 0 and Wrap=1; PCld LdAddr=50 -> 50 and Wrap=0.
